pdp11_fetch: RTL and testbench
==============================

Name: pdp11_fetch

Overview:
Instruction-fetch sequencer that sits directly in front of the register file and drives it.
- Reads PC through the regfile B bus and issues a memory read with a req/ack handshake.
- Writes PC+2 back through the regfile write port.
- Presents the fetched word to the decoder with a valid/ready handshake.
- Detects odd-PC, bus-error and bus-timeout faults, and reports them to the trap logic.

Parameters:
TIMEOUT, 16, bus cycles to wait for mem_ack before a timeout fault (legal range 2..255).
PC_INC, 2, PC increment per fetched word.

Ports:
clk  in  1  clock; all state changes on posedge.
reset  in  1  synchronous, active-high reset.
halt  in  1  when high in LOADPC, no new fetch starts.
sela  out  3  regfile A select; constant 7.
selb  out  3  regfile B select / write select; constant 7 (PC).
we  out  1  regfile write enable.
w  out  16  regfile write data (new PC).
a  in  16  regfile A bus; unused, kept for port symmetry.
b  in  16  regfile B bus; current PC.
mem_addr  out  16  fetch address.
mem_req  out  1  memory read request.
mem_ack  in  1  memory read complete.
mem_err  in  1  bus error; qualified by mem_ack.
mem_rdata  in  16  read data; qualified by mem_ack.
ir  out  16  fetched instruction word.
ir_valid  out  1  ir holds a new instruction.
ir_ready  in  1  decoder accepts ir.
fetch_err  out  1  sticky fault flag.
err_code  out  2  fault cause: 0 none, 1 odd PC, 2 bus error, 3 timeout.

Behaviour:
- Reset (synchronous, active-high):
  - State goes to IDLE.
  - mem_req=0, mem_addr=0, we=0, w=0, ir=0, ir_valid=0, fetch_err=0, err_code=0, timer=0.
  - sela and selb are always 7.
  - Reset asserted in any state aborts a pending request immediately; a late mem_ack is ignored.
- States: IDLE, LOADPC, WAIT, WRPC, VALID, ERROR. All outputs are registered.
- IDLE:
  - Lasts one cycle, then goes to LOADPC.
  - This gives the regfile PC clear time to settle.
- LOADPC:
  - If halt=1, stay in LOADPC.
  - Else latch pc_q<=b.
  - If b[0]=1, go to ERROR with err_code=1.
  - Else set mem_addr<=b, mem_req<=1, timer<=0, and go to WAIT.
- WAIT:
  - mem_req and mem_addr are held stable until mem_ack is sampled high.
  - mem_ack=1 and mem_err=1: mem_req<=0, go to ERROR with err_code=2.
  - mem_ack=1 and mem_err=0: ir<=mem_rdata, mem_req<=0, we<=1, w<=pc_q+PC_INC (mod 2^16; FFFE wraps to 0000), go to WRPC.
  - mem_ack=0: timer increments each cycle.
    - When timer reaches TIMEOUT-1 with no ack, set mem_req<=0 and go to ERROR with err_code=3.
    - The timeout therefore occurs after exactly TIMEOUT WAIT cycles.
    - mem_ack arriving in that same cycle wins over the timeout.
- WRPC:
  - we=1 for exactly one cycle; the regfile writes PC on this edge.
  - Next: we<=0, ir_valid<=1, go to VALID.
- VALID:
  - ir_valid and ir are held stable until ir_ready is sampled high.
  - Then ir_valid<=0 and go to LOADPC.
  - ir_ready while ir_valid=0 has no effect.
- ERROR:
  - Sticky; only reset exits.
  - fetch_err=1, err_code held; mem_req=0, we=0, ir_valid=0.
  - mem_ack, mem_err and ir_ready are ignored.
- Timing:
  - Zero-wait memory (ack in the first WAIT cycle): ir_valid rises 3 cycles after entering LOADPC.
  - Throughput is 1 instruction per 4 cycles with ir_ready tied high.
- PC lives only in the regfile; this block keeps no architectural copy beyond pc_q for the increment.
- No write to PC occurs on any fault; the PC keeps the faulting address for the trap handler.

Decomposition:
- Shared include pdp11_defs.vh holds:
  - state encodings (3 bits);
  - ERR_NONE/ERR_ODD/ERR_BUS/ERR_TMO codes;
  - REG_PC=7, REG_SP=6.
- Sub-module pdp11_bus_timer: clear/enable counter with an expired output sized from TIMEOUT.
  - It is reused later by the data-access sequencer.

Test Plan:
1. Reset, then PC=0100, memory returns 012700 with 0-wait ack, ir_ready=1 -> mem_addr=0100 one cycle after LOADPC; regfile write PC:=0102 with we high one cycle; ir=012700 with ir_valid high; next mem_addr=0102.
2. ir_ready held 0 for 5 cycles -> ir_valid and ir stable for all 5 cycles; no mem_req; fetch resumes the cycle after ir_ready=1.
3. PC=0101 -> no mem_req; fetch_err=1, err_code=1; PC unchanged; stays in ERROR until reset.
4. mem_ack never asserted, TIMEOUT=16 -> mem_req high exactly 16 cycles, then drops; err_code=3. Separately, ack in cycle 16 -> normal completion.
5. mem_ack with mem_err=1 at PC=0200 -> err_code=2; no regfile write; PC still 0200.
6. PC=FFFE fetch -> w=0000. Separately, reset asserted mid-WAIT -> all outputs at reset values next cycle, and an ack the following cycle is ignored.

Source files
------------

// File: rtl/pdp11_fetch_pkg.sv
// Shared definitions for the PDP-11 fetch path: sequencer states, fault codes
// and the register number of the PC.
package pdp11_fetch_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOADPC = 3'd1,
    ST_WAIT   = 3'd2,
    ST_WRPC   = 3'd3,
    ST_VALID  = 3'd4,
    ST_ERROR  = 3'd5
  } fetch_state_e;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_ODD  = 2'd1;
  localparam logic [1:0] ERR_BUS  = 2'd2;
  localparam logic [1:0] ERR_TMO  = 2'd3;

  localparam logic [2:0] REG_PC = 3'd7;

  // 16-bit PC advance; wraps modulo 2^16
  function automatic logic [15:0] pc_advance(input logic [15:0] pc, input logic [15:0] inc);
    return pc + inc;
  endfunction

endpackage

// File: rtl/pdp11_fetch_if.sv
// Fetch-side bus bundle: memory read handshake plus the decoder valid/ready handshake.
interface pdp11_fetch_if;
  logic [15:0] mem_addr;
  logic        mem_req;
  logic        mem_ack;
  logic        mem_err;
  logic [15:0] mem_rdata;
  logic [15:0] ir;
  logic        ir_valid;
  logic        ir_ready;

  modport master (
    output mem_addr, mem_req, ir, ir_valid,
    input  mem_ack, mem_err, mem_rdata, ir_ready
  );

  modport slave (
    input  mem_addr, mem_req, ir, ir_valid,
    output mem_ack, mem_err, mem_rdata, ir_ready
  );
endinterface

// File: rtl/pdp11_bus_timer.sv
// Bus-cycle watchdog: clearable, enabled counter that flags the last allowed cycle.
module pdp11_bus_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT);
  localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

  logic [W-1:0] count_r;

  // Count enabled cycles, saturating at the last allowed cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r <= '0;
    end else if (clear) begin
      count_r <= '0;
    end else if (enable && (count_r != LAST)) begin
      count_r <= count_r + W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign expired = (count_r == LAST);

endmodule

// File: rtl/pdp11_fetch.sv
// PDP-11 instruction-fetch sequencer: reads PC from the regfile, fetches one word,
// writes PC+PC_INC back and hands the word to the decoder; faults are sticky.
module pdp11_fetch
  import pdp11_fetch_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int PC_INC  = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          halt,
  output logic [2:0]    sela,
  output logic [2:0]    selb,
  output logic          we,
  output logic [15:0]   w,
  input  logic [15:0]   a,
  input  logic [15:0]   b,
  pdp11_fetch_if.master bus,
  output logic          fetch_err,
  output logic [1:0]    err_code
);

  localparam logic [15:0] PC_INC_W = 16'(PC_INC);

  fetch_state_e state_r, state_s;
  logic [15:0]  pc_q_r, pc_q_s;
  logic [15:0]  mem_addr_r, mem_addr_s;
  logic         mem_req_r, mem_req_s;
  logic         we_r, we_s;
  logic [15:0]  w_r, w_s;
  logic [15:0]  ir_r, ir_s;
  logic         ir_valid_r, ir_valid_s;
  logic         fetch_err_r, fetch_err_s;
  logic [1:0]   err_code_r, err_code_s;
  logic         tmr_clear_s, tmr_en_s, tmr_expired_s;
  logic         unused_a_s;

  assign unused_a_s = ^a;

  pdp11_bus_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (tmr_clear_s),
    .enable  (tmr_en_s),
    .expired (tmr_expired_s)
  );

  // Next-state and next-output decode
  always_comb begin
    state_s     = state_r;
    pc_q_s      = pc_q_r;
    mem_addr_s  = mem_addr_r;
    mem_req_s   = mem_req_r;
    we_s        = 1'b0;
    w_s         = w_r;
    ir_s        = ir_r;
    ir_valid_s  = ir_valid_r;
    fetch_err_s = fetch_err_r;
    err_code_s  = err_code_r;
    tmr_clear_s = 1'b0;
    tmr_en_s    = 1'b0;

    case (state_r)
      ST_IDLE: begin
        state_s = ST_LOADPC;
      end
      ST_LOADPC: begin
        tmr_clear_s = 1'b1;
        if (halt) begin
          state_s = ST_LOADPC;
        end else begin
          pc_q_s = b;
          if (b[0]) begin
            state_s     = ST_ERROR;
            fetch_err_s = 1'b1;
            err_code_s  = ERR_ODD;
          end else begin
            mem_addr_s = b;
            mem_req_s  = 1'b1;
            state_s    = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        tmr_en_s = 1'b1;
        // An ack in the expiry cycle still completes the fetch
        if (bus.mem_ack) begin
          mem_req_s = 1'b0;
          if (bus.mem_err) begin
            state_s     = ST_ERROR;
            fetch_err_s = 1'b1;
            err_code_s  = ERR_BUS;
          end else begin
            ir_s    = bus.mem_rdata;
            we_s    = 1'b1;
            w_s     = pc_advance(pc_q_r, PC_INC_W);
            state_s = ST_WRPC;
          end
        end else if (tmr_expired_s) begin
          mem_req_s   = 1'b0;
          state_s     = ST_ERROR;
          fetch_err_s = 1'b1;
          err_code_s  = ERR_TMO;
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_WRPC: begin
        ir_valid_s = 1'b1;
        state_s    = ST_VALID;
      end
      ST_VALID: begin
        if (bus.ir_ready) begin
          ir_valid_s = 1'b0;
          state_s    = ST_LOADPC;
        end else begin
          state_s = ST_VALID;
        end
      end
      ST_ERROR: begin
        fetch_err_s = 1'b1;
        mem_req_s   = 1'b0;
        ir_valid_s  = 1'b0;
        state_s     = ST_ERROR;
      end
      default: begin
        state_s    = ST_IDLE;
        mem_req_s  = 1'b0;
        ir_valid_s = 1'b0;
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      pc_q_r      <= 16'h0000;
      mem_addr_r  <= 16'h0000;
      mem_req_r   <= 1'b0;
      we_r        <= 1'b0;
      w_r         <= 16'h0000;
      ir_r        <= 16'h0000;
      ir_valid_r  <= 1'b0;
      fetch_err_r <= 1'b0;
      err_code_r  <= ERR_NONE;
    end else begin
      state_r     <= state_s;
      pc_q_r      <= pc_q_s;
      mem_addr_r  <= mem_addr_s;
      mem_req_r   <= mem_req_s;
      we_r        <= we_s;
      w_r         <= w_s;
      ir_r        <= ir_s;
      ir_valid_r  <= ir_valid_s;
      fetch_err_r <= fetch_err_s;
      err_code_r  <= err_code_s;
    end
  end

  assign sela         = REG_PC;
  assign selb         = REG_PC;
  assign we           = we_r;
  assign w            = w_r;
  assign bus.mem_addr = mem_addr_r;
  assign bus.mem_req  = mem_req_r;
  assign bus.ir       = ir_r;
  assign bus.ir_valid = ir_valid_r;
  assign fetch_err    = fetch_err_r;
  assign err_code     = err_code_r;

endmodule

// File: tb/tb_pdp11_fetch.sv
// Bench for pdp11_fetch: regfile/memory models plus a per-cycle transaction-level checker.
module tb_pdp11_fetch;
  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        halt = 1'b0;
  logic [2:0]  sela, selb;
  logic        we;
  logic [15:0] w;
  logic [15:0] a = 16'h0000;
  logic [15:0] b = 16'h0000;
  logic        fetch_err;
  logic [1:0]  err_code;

  pdp11_fetch_if bus();

  pdp11_fetch #(.TIMEOUT(TMO), .PC_INC(2)) dut (
    .clk(clk), .reset(reset), .halt(halt), .sela(sela), .selb(selb),
    .we(we), .w(w), .a(a), .b(b), .bus(bus),
    .fetch_err(fetch_err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [15:0] pc_reg = 16'h0000;
  logic [15:0] exp_ir = 16'h0000;
  int resp_mode = 0;   // 0 good data, 1 bus error, 2 never ack
  int resp_lat = 0;
  int wait_cnt = 0;
  int req_cnt = 0;
  bit force_ack = 1'b0;
  bit ack_forced = 1'b0;
  logic        p_req = 1'b0, p_we = 1'b0, p_ivalid = 1'b0, p_err = 1'b0;
  logic [15:0] p_addr = 16'h0000, p_w = 16'h0000, p_ir = 16'h0000;
  logic [1:0]  p_code = 2'd0;
  logic        m_ivalid = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] mem_word(input logic [15:0] addr);
    if (addr == 16'o000100) return 16'o012700;
    return addr ^ 16'h5A5A;
  endfunction

  // One clock: regfile update, model compare, memory responder
  task automatic step();
    logic rst_in, ack_in, good_in, rdy_in;
    logic [15:0] pc_plus;
    @(negedge clk);
    if (p_we) pc_reg = p_w;
    b = pc_reg;
    rst_in  = reset;
    ack_in  = bus.mem_ack;
    good_in = bus.mem_ack && !bus.mem_err && !ack_forced;
    rdy_in  = bus.ir_ready;
    pc_plus = pc_reg + 16'd2;

    check("sela", sela, 3'd7);
    check("selb", selb, 3'd7);
    if (rst_in) begin
      check("rst_req", bus.mem_req, 1'b0);
      check("rst_addr", bus.mem_addr, 16'h0000);
      check("rst_we", we, 1'b0);
      check("rst_w", w, 16'h0000);
      check("rst_ir", bus.ir, 16'h0000);
      check("rst_ivalid", bus.ir_valid, 1'b0);
      check("rst_err", fetch_err, 1'b0);
      check("rst_code", err_code, 2'd0);
      m_ivalid = 1'b0;
    end else begin
      check("we_after_good_ack", we, good_in);
      if (we) check("w_pc_plus_2", w, pc_plus);
      if (p_we) m_ivalid = 1'b1;
      else if (p_ivalid && rdy_in) m_ivalid = 1'b0;
      check("ir_valid", bus.ir_valid, m_ivalid);
      if (bus.ir_valid) check("ir_word", bus.ir, exp_ir);
      if (p_req) begin
        check("req_hold", bus.mem_req, (!ack_in && req_cnt < TMO));
        if (bus.mem_req) check("addr_hold", bus.mem_addr, p_addr);
      end else if (bus.mem_req) begin
        check("req_addr_is_pc", bus.mem_addr, pc_reg);
        check("req_addr_even", bus.mem_addr[0], 1'b0);
      end
      if (fetch_err) begin
        check("err_quiet", {bus.mem_req, we, bus.ir_valid}, 3'b000);
        check("err_code_set", (err_code != 2'd0), 1'b1);
      end else begin
        check("code_none", err_code, 2'd0);
      end
      if (p_err) begin
        check("err_sticky", fetch_err, 1'b1);
        check("code_sticky", err_code, p_code);
      end
    end

    req_cnt  = bus.mem_req ? req_cnt + 1 : 0;
    p_req    = bus.mem_req;  p_addr = bus.mem_addr;
    p_we     = we;           p_w    = w;
    p_ivalid = bus.ir_valid; p_ir   = bus.ir;
    p_err    = fetch_err;    p_code = err_code;

    ack_forced = 1'b0;
    if (force_ack) begin
      bus.mem_ack = 1'b1; bus.mem_err = 1'b0; bus.mem_rdata = 16'hDEAD;
      ack_forced = 1'b1; force_ack = 1'b0;
    end else if (bus.mem_req && resp_mode != 2 && wait_cnt == resp_lat) begin
      bus.mem_ack = 1'b1;
      bus.mem_err = (resp_mode == 1);
      bus.mem_rdata = mem_word(bus.mem_addr);
      if (resp_mode == 0) exp_ir = bus.mem_rdata;
    end else begin
      bus.mem_ack = 1'b0; bus.mem_err = 1'b0;
    end
    wait_cnt = bus.mem_req ? wait_cnt + 1 : 0;
  endtask

  task automatic apply_reset(input logic [15:0] pc);
    reset = 1'b1;
    pc_reg = pc;
    resp_mode = 0; resp_lat = 0;
    step(); step();
    reset = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    bit seen_we;
    bus.mem_ack = 1'b0; bus.mem_err = 1'b0; bus.mem_rdata = 16'h0000; bus.ir_ready = 1'b1;

    // Zero-wait fetch at 0100
    apply_reset(16'o000100);
    step(); check("t1_idle_noreq", bus.mem_req, 1'b0);
    step(); check("t1_req", bus.mem_req, 1'b1); check("t1_addr", bus.mem_addr, 16'o000100);
    step(); check("t1_we", we, 1'b1); check("t1_w", w, 16'o000102);
    step(); check("t1_we_off", we, 1'b0); check("t1_ivalid", bus.ir_valid, 1'b1);
    check("t1_ir", bus.ir, 16'o012700);
    step(); check("t1_accept", bus.ir_valid, 1'b0);
    step(); check("t1_next_req", bus.mem_req, 1'b1); check("t1_next_addr", bus.mem_addr, 16'o000102);

    // Decoder back-pressure
    bus.ir_ready = 1'b0;
    step(); check("t2_we", we, 1'b1); check("t2_w", w, 16'o000104);
    step(); check("t2_ivalid", bus.ir_valid, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step();
      check("t2_hold_valid", bus.ir_valid, 1'b1);
      check("t2_hold_ir", bus.ir, 16'h5A18);
      check("t2_no_req", bus.mem_req, 1'b0);
    end
    bus.ir_ready = 1'b1;
    step(); check("t2_accept", bus.ir_valid, 1'b0); check("t2_loadpc_noreq", bus.mem_req, 1'b0);
    step(); check("t2_resume_req", bus.mem_req, 1'b1); check("t2_resume_addr", bus.mem_addr, 16'o000104);

    // Halt holds the sequencer in LOADPC
    halt = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step(); check("halt_noreq", bus.mem_req, 1'b0);
    end
    check("halt_pc", pc_reg, 16'o000106);
    halt = 1'b0;
    step(); check("halt_resume", bus.mem_req, 1'b1); check("halt_addr", bus.mem_addr, 16'o000106);

    // Odd PC
    apply_reset(16'o000101);
    step();
    step(); check("t3_err", fetch_err, 1'b1); check("t3_code", err_code, 2'd1);
    check("t3_noreq", bus.mem_req, 1'b0);
    for (int i = 0; i < 6; i++) begin
      force_ack = (i % 2 == 0);
      bus.ir_ready = (i % 2 == 1);
      step(); check("t3_stuck", err_code, 2'd1); check("t3_no_we", we, 1'b0);
    end
    bus.ir_ready = 1'b1;
    check("t3_pc_kept", pc_reg, 16'o000101);

    // Timeout without ack
    apply_reset(16'o000300);
    resp_mode = 2;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (bus.mem_req) cnt++;
      else if (cnt > 0) break;
    end
    check("t4_req_cycles", cnt, TMO);
    check("t4_err", fetch_err, 1'b1); check("t4_code", err_code, 2'd3);
    check("t4_pc_kept", pc_reg, 16'o000300);

    // Ack in the last allowed cycle completes normally
    apply_reset(16'o000300);
    resp_lat = TMO - 1;
    cnt = 0; seen_we = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (bus.mem_req) cnt++;
      if (we) begin seen_we = 1'b1; break; end
    end
    check("t4b_we", seen_we, 1'b1); check("t4b_req_cycles", cnt, TMO);
    check("t4b_w", w, 16'o000302); check("t4b_no_err", fetch_err, 1'b0);
    step(); check("t4b_ivalid", bus.ir_valid, 1'b1); check("t4b_ir", bus.ir, 16'h5A9A);

    // Bus error
    apply_reset(16'o000200);
    resp_mode = 1; resp_lat = 2;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus.mem_req) cnt++;
      if (fetch_err) break;
    end
    check("t5_req_cycles", cnt, 3); check("t5_code", err_code, 2'd2);
    for (int i = 0; i < 4; i++) begin
      step(); check("t5_no_we", we, 1'b0);
    end
    check("t5_pc_kept", pc_reg, 16'o000200);

    // PC wrap
    apply_reset(16'hFFFE);
    step();
    step(); check("t6_addr", bus.mem_addr, 16'hFFFE);
    step(); check("t6_we", we, 1'b1); check("t6_w_wrap", w, 16'h0000);
    step(); check("t6_ir", bus.ir, 16'hA5A4);
    step();
    step(); check("t6_next_addr", bus.mem_addr, 16'h0000); check("t6_next_req", bus.mem_req, 1'b1);

    // Reset mid-WAIT, then a stray ack
    apply_reset(16'o000400);
    resp_mode = 2;
    step(); step(); step();
    check("t6b_waiting", bus.mem_req, 1'b1);
    reset = 1'b1; force_ack = 1'b1;
    step(); check("t6b_rst_req", bus.mem_req, 1'b0); check("t6b_rst_addr", bus.mem_addr, 16'h0000);
    reset = 1'b0;
    step(); check("t6b_ack_ignored_we", we, 1'b0); check("t6b_ack_ignored_valid", bus.ir_valid, 1'b0);
    check("t6b_no_err", fetch_err, 1'b0); check("t6b_idle_noreq", bus.mem_req, 1'b0);
    resp_mode = 0;
    step(); check("t6b_refetch", bus.mem_req, 1'b1); check("t6b_refetch_addr", bus.mem_addr, 16'o000400);
    step(); check("t6b_we", we, 1'b1); check("t6b_w", w, 16'o000402);
    step(); step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
